// File: rtl/udp_tx_cmd_seq.sv
// UDP command sequencer: on key press or start, sends a 2-byte mode-select frame,
// waits a gap, then sends the per-mode payload frame and advances the active mode.
module udp_tx_cmd_seq #(
    parameter int          NUM_MODES    = 4,
    parameter int          MAX_LEN      = 8,
    parameter int          DEBOUNCE_CYC = 1000000,
    parameter int          GAP_CYC      = 10000,
    parameter int          ACK_TIMEOUT  = 65535,
    parameter logic [7:0]  CMD_HDR      = 8'h00,
    parameter logic [7:0]  CMD_BASE     = 8'h02,
    localparam int         MW           = $clog2(NUM_MODES)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            key_n,
    input  logic                            start,
    input  logic [NUM_MODES*MAX_LEN*8-1:0]  mode_payload,
    input  logic [NUM_MODES*8-1:0]          mode_len,
    input  logic                            udp_tx_ready,
    input  logic                            app_tx_ack,
    output logic                            app_tx_data_request,
    output logic                            app_tx_data_valid,
    output logic [7:0]                      app_tx_data,
    output logic [15:0]                     udp_data_length,
    output logic [MW-1:0]                   cur_mode,
    output logic                            busy,
    output logic                            timeout_err
);

    localparam int DBW = $clog2(DEBOUNCE_CYC + 2);
    localparam int GW  = $clog2(GAP_CYC + 2);
    localparam int TW  = $clog2(ACK_TIMEOUT + 2);

    typedef enum logic [3:0] {
        IDLE, CMD_REQ, CMD_ACK, CMD_DATA, GAP, DAT_REQ, DAT_ACK, DAT_DATA, DONE
    } state_t;

    // key_n is asynchronous, so it passes a two-flop synchroniser before debouncing
    logic           key_meta_q, key_sync_q, key_stable_q, key_stable_d1_q;
    logic [DBW-1:0] dbc_cnt_q;
    logic           press, trig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q      <= 1'b1;
            key_sync_q      <= 1'b1;
            key_stable_q    <= 1'b1;
            key_stable_d1_q <= 1'b1;
            dbc_cnt_q       <= '0;
        end else begin
            key_meta_q      <= key_n;
            key_sync_q      <= key_meta_q;
            key_stable_d1_q <= key_stable_q;
            if (key_sync_q == key_stable_q) begin
                dbc_cnt_q <= '0;
            end else if (dbc_cnt_q >= DBW'(DEBOUNCE_CYC)) begin
                key_stable_q <= key_sync_q;
                dbc_cnt_q    <= '0;
            end else begin
                dbc_cnt_q <= dbc_cnt_q + DBW'(1);
            end
        end
    end

    assign press = key_stable_d1_q & ~key_stable_q;
    assign trig  = press | start;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d, len_q, len_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [TW-1:0]  to_q, to_d;
    logic           abort_q, abort_d, req_q, req_d, valid_q, valid_d, terr_q, terr_d;
    logic [7:0]     data_q, data_d;
    logic [15:0]    dlen_q, dlen_d;
    logic [MW-1:0]  mode_q, mode_d;

    logic [7:0]     pay_idx, pay_byte, sel_len, len_clamped;

    always_comb begin
        pay_idx  = (state_q == DAT_DATA) ? cnt_q : 8'd0;
        pay_byte = '0;
        sel_len  = '0;
        for (int unsigned m = 0; m < NUM_MODES; m++) begin
            if (mode_q == MW'(m)) begin
                sel_len = mode_len[m*8 +: 8];
                for (int unsigned k = 0; k < MAX_LEN; k++) begin
                    if (pay_idx == 8'(k)) pay_byte = mode_payload[(m*MAX_LEN+k)*8 +: 8];
                end
            end
        end
        len_clamped = (sel_len > 8'(MAX_LEN)) ? 8'(MAX_LEN) : sel_len;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        gap_d   = gap_q;
        to_d    = to_q;
        abort_d = abort_q;
        req_d   = req_q;
        valid_d = valid_q;
        data_d  = data_q;
        dlen_d  = dlen_q;
        mode_d  = mode_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: if (trig) begin
                len_d   = len_clamped;
                dlen_d  = 16'd2;
                terr_d  = 1'b0;
                abort_d = 1'b0;
                state_d = CMD_REQ;
            end
            CMD_REQ, DAT_REQ: if (udp_tx_ready) begin
                req_d   = 1'b1;
                to_d    = '0;
                state_d = (state_q == CMD_REQ) ? CMD_ACK : DAT_ACK;
            end
            CMD_ACK, DAT_ACK: begin
                // ack takes priority over an expiring timeout in the same cycle
                if (app_tx_ack) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    data_d  = (state_q == CMD_ACK) ? CMD_HDR : pay_byte;
                    cnt_d   = 8'd1;
                    state_d = (state_q == CMD_ACK) ? CMD_DATA : DAT_DATA;
                end else if (to_q >= TW'(ACK_TIMEOUT)) begin
                    req_d   = 1'b0;
                    terr_d  = 1'b1;
                    abort_d = 1'b1;
                    state_d = DONE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            CMD_DATA: begin
                if (cnt_q < 8'd2) begin
                    data_d = CMD_BASE + 8'(mode_q);
                    cnt_d  = cnt_q + 8'd1;
                end else begin
                    valid_d = 1'b0;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q >= GW'(GAP_CYC)) begin
                    dlen_d  = {8'h00, len_q};
                    state_d = (len_q != 8'd0) ? DAT_REQ : DONE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            DAT_DATA: begin
                if (cnt_q < len_q) begin
                    data_d = pay_byte;
                    cnt_d  = cnt_q + 8'd1;
                end else begin
                    valid_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!abort_q) mode_d = (mode_q == MW'(NUM_MODES-1)) ? '0 : mode_q + MW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            to_q    <= '0;
            abort_q <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            dlen_q  <= 16'd2;
            mode_q  <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            to_q    <= to_d;
            abort_q <= abort_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            dlen_q  <= dlen_d;
            mode_q  <= mode_d;
            terr_q  <= terr_d;
        end
    end

    assign app_tx_data_request = req_q;
    assign app_tx_data_valid   = valid_q;
    assign app_tx_data         = data_q;
    assign udp_data_length     = dlen_q;
    assign cur_mode            = mode_q;
    assign busy                = (state_q != IDLE);
    assign timeout_err         = terr_q;

endmodule

// File: tb/tb_udp_tx_cmd_seq.sv
// Scoreboard bench for udp_tx_cmd_seq: expected bytes are queued by the stimulus,
// a monitor pops and compares every valid byte.
module tb_udp_tx_cmd_seq;
    localparam int NM  = 4;
    localparam int ML  = 8;
    localparam int DB  = 16;
    localparam int GAP = 5;
    localparam int TO  = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              key_n = 1'b1;
    logic              start = 1'b0;
    logic              ready = 1'b1;
    logic              ack = 1'b0;
    logic [NM*ML*8-1:0] payload = '0;
    logic [NM*8-1:0]    lens = '0;
    logic              req, valid, busy, terr;
    logic [7:0]        data;
    logic [15:0]       len_o;
    logic [1:0]        mode;

    always #5 clk = ~clk;

    udp_tx_cmd_seq #(
        .NUM_MODES(NM), .MAX_LEN(ML), .DEBOUNCE_CYC(DB), .GAP_CYC(GAP),
        .ACK_TIMEOUT(TO), .CMD_HDR(8'h00), .CMD_BASE(8'h02)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_n(key_n), .start(start),
        .mode_payload(payload), .mode_len(lens),
        .udp_tx_ready(ready), .app_tx_ack(ack),
        .app_tx_data_request(req), .app_tx_data_valid(valid), .app_tx_data(data),
        .udp_data_length(len_o), .cur_mode(mode), .busy(busy), .timeout_err(terr)
    );

    int checks = 0;
    int errors = 0;
    bit ack_en = 1'b1;

    typedef struct { logic [7:0] d; logic [15:0] l; } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_byte(input int m, input int k, input logic [7:0] v);
        payload[(m*ML+k)*8 +: 8] = v;
    endtask

    task automatic set_len(input int m, input logic [7:0] n);
        lens[m*8 +: 8] = n;
    endtask

    task automatic push_frames(input int m, input int n);
        exp_t e;
        e.l = 16'd2; e.d = 8'h00;           exp_q.push_back(e);
        e.d = 8'h02 + 8'(m);                exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            e.l = 16'(n);
            e.d = payload[(m*ML+k)*8 +: 8];
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_busy(input logic v, input int budget, input string name);
        int i = 0;
        while (busy !== v && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(name, busy, v);
    endtask

    task automatic watch_idle(input int cyc, input string name);
        int seen = 0;
        repeat (cyc) begin
            @(negedge clk);
            if (busy) seen = 1;
        end
        chk(name, seen, 0);
    endtask

    // monitor: every valid byte must match the head of the expected queue
    initial forever begin
        @(negedge clk);
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %02h expected none", data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("frame_byte", data, e.d);
                chk("frame_len", len_o, e.l);
            end
        end
    end

    // ack responder: grants one cycle after request is seen; data frames only when ack_en
    initial forever begin
        @(negedge clk);
        if (rst_n && req && !ack && (ack_en || len_o == 16'd2)) begin
            @(negedge clk) ack = 1'b1;
            @(negedge clk) ack = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int exp_n[4] = '{1, 5, 8, 8};

    initial begin
        int n;
        int hi;
        set_byte(0, 0, 8'hAF); set_byte(0, 1, 8'h0F); set_byte(0, 2, 8'hF0);
        set_len(0, 8'd3);

        repeat (3) @(negedge clk);
        chk("rst_len_in_reset", len_o, 16'd2);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_len", len_o, 16'd2);
        chk("rst_mode", mode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", terr, 0);

        // mode 0, payload AF 0F F0
        push_frames(0, 3);
        pulse_start();
        chk("start_latency_busy", busy, 1);
        n = 0;
        while (!valid && n < 100) begin @(negedge clk); n++; end
        chk("cmd_valid_seen", valid, 1);
        n = 0;
        while (valid && n < 100) begin @(negedge clk); n++; end
        chk("cmd_valid_cycles", n, 2);
        n = 0;
        while (!req && n < 100) begin @(negedge clk); n++; end
        chk("gap_cycles", n, GAP + 2);
        wait_busy(1'b0, 200, "seq0_done");
        chk("mode_after_seq0", mode, 1);
        chk("queue_empty_seq0", exp_q.size(), 0);

        for (int m = 0; m < NM; m++)
            for (int k = 0; k < ML; k++) set_byte(m, k, 8'(8'h11 * (m + 1) + k));
        set_len(0, 8'd1); set_len(1, 8'd5); set_len(2, 8'd8); set_len(3, 8'd12);

        // short key glitch must not trigger
        key_n = 1'b0;
        repeat (8) @(negedge clk);
        key_n = 1'b1;
        watch_idle(40, "bounce_ignored");

        push_frames(1, 5);
        key_n = 1'b0;
        wait_busy(1'b1, 60, "key_press_start");
        wait_busy(1'b0, 300, "key_seq_done");
        key_n = 1'b1;
        watch_idle(40, "key_release_no_seq");
        chk("mode_after_key", mode, 2);

        // four triggers: modes 2,3,0,1 with lengths 8,8(clamped),1,5
        for (int i = 0; i < 4; i++) begin
            int m;
            m = (2 + i) % 4;
            push_frames(m, exp_n[m]);
            pulse_start();
            wait_busy(1'b0, 300, "wrap_seq_done");
            chk("mode_wrap", mode, (m + 1) % 4);
        end
        chk("queue_empty_wrap", exp_q.size(), 0);

        // data ack withheld: timeout after ACK_TIMEOUT+1 request cycles
        set_len(2, 8'd5);
        ack_en = 1'b0;
        push_frames(2, 0);
        pulse_start();
        n = 0; hi = 0;
        while (!terr && n < 400) begin
            @(negedge clk);
            n++;
            if (req && len_o == 16'd5) hi++;
        end
        chk("timeout_err_set", terr, 1);
        chk("timeout_req_cycles", hi, TO + 1);
        chk("timeout_req_low", req, 0);
        wait_busy(1'b0, 10, "timeout_idle");
        chk("timeout_mode_kept", mode, 2);
        ack_en = 1'b1;

        // zero length: command frame only; start while busy ignored
        set_len(2, 8'd0);
        push_frames(2, 0);
        pulse_start();
        chk("terr_cleared", terr, 0);
        chk("zero_busy", busy, 1);
        repeat (3) @(negedge clk);
        pulse_start();
        wait_busy(1'b0, 200, "zero_done");
        chk("mode_after_zero", mode, 3);
        watch_idle(30, "busy_start_ignored");
        chk("queue_empty_zero", exp_q.size(), 0);

        // reset during data frame
        push_frames(3, 8);
        pulse_start();
        n = 0;
        while (!(valid && len_o == 16'd8) && n < 200) begin @(negedge clk); n++; end
        chk("data_frame_seen", valid, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", req, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_len", len_o, 16'd2);
        chk("midrst_mode", mode, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        watch_idle(10, "post_reset_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/udp_tx_cmd_seq.md
# udp_tx_cmd_seq

Parametrised UDP command sequencer. On a debounced key press or a `start` pulse it transmits two UDP frames through the application-side UDP TX handshake. The first is a 2-byte mode-select command. After a programmable gap, the second is a per-mode payload of up to `MAX_LEN` bytes. On success the active mode then advances cyclically through `NUM_MODES`. The block sits between board keys or control logic and the UDP stack's app TX port. It adds ack timeout, error reporting and run-time payload tables.

## Interface
- `NUM_MODES`, 4: number of modes, ≥2; `MW = $clog2(NUM_MODES)`.
- `MAX_LEN`, 8: maximum payload bytes per mode, 1..255.
- `DEBOUNCE_CYC`, 1000000: key debounce threshold in cycles.
- `GAP_CYC`, 10000: idle cycles between the command frame and the data frame.
- `ACK_TIMEOUT`, 65535: cycles allowed in an ack-wait state.
- `CMD_HDR`, 8'h00: command byte 0.
- `CMD_BASE`, 8'h02: command byte 1 is `CMD_BASE + cur_mode` (mod 256).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `key_n` in 1: raw key, active-low, asynchronous to `clk`.
- `start` in 1: single-cycle trigger, equivalent to a key press.
- `mode_payload` in `NUM_MODES*MAX_LEN*8`: byte k of mode m is at `[(m*MAX_LEN+k)*8 +: 8]`; byte 0 is sent first.
- `mode_len` in `NUM_MODES*8`: payload length of mode m is at `[m*8 +: 8]`.
- `udp_tx_ready` in 1: UDP stack can accept a request.
- `app_tx_ack` in 1: UDP stack grants the pending request.
- `app_tx_data_request` out 1: frame request.
- `app_tx_data_valid` out 1: payload byte valid.
- `app_tx_data` out 8: payload byte.
- `udp_data_length` out 16: length of the current frame.
- `cur_mode` out `MW`: active mode.
- `busy` out 1: high whenever the state is not IDLE.
- `timeout_err` out 1: sticky; set on ack timeout, cleared by the next accepted trigger.

## Operation
- **Debounce**
  - `key_stable` resets to 1.
  - Counter clears while `key_n == key_stable` and increments otherwise.
  - At count ≥ `DEBOUNCE_CYC`: `key_stable <= key_n` and the counter clears.
  - `press` is a 1-cycle pulse on the falling edge of `key_stable`, generated one cycle after `key_stable` changes.
- **Trigger**
  - `trig = press | start`. It is accepted only in IDLE; otherwise ignored, with no queuing.
  - `press` and `start` in the same cycle give one sequence.
- **On accept**
  - Latch `len = min(mode_len[cur_mode], MAX_LEN)`.
  - Set `udp_data_length <= 2`, clear `timeout_err`, go to CMD_REQ.
  - `mode_payload` must be held stable while `busy`.
- **States**: IDLE, CMD_REQ, CMD_ACK, CMD_DATA, GAP, DAT_REQ, DAT_ACK, DAT_DATA, DONE.
- **CMD_REQ / DAT_REQ**: when `udp_tx_ready=1`, assert request and go to the matching ACK state; otherwise keep request low and wait.
- **CMD_ACK / DAT_ACK**
  - Hold request high.
  - On `app_tx_ack`: request goes to 0, valid goes to 1, byte 0 is driven, `cnt=1`, go to the matching DATA state.
  - Timeout counter clears on entry. When it reaches `ACK_TIMEOUT` without ack: request goes to 0, `timeout_err` goes to 1, go to DONE with the abort flag set.
- **CMD_DATA**
  - Sends `CMD_HDR` then `CMD_BASE + cur_mode`.
  - After 2 bytes, valid goes to 0 and the block enters GAP.
- **GAP**
  - Waits `GAP_CYC` cycles, then sets `udp_data_length <= len`.
  - Goes to DAT_REQ if `len > 0`; goes straight to DONE (success) if `len == 0`.
- **DAT_DATA**
  - While `cnt < len`: drive byte `cnt`, keep valid at 1, increment `cnt`.
  - When `cnt == len`: valid goes to 0, go to DONE.
- **DONE**
  - On success: `cur_mode <= (cur_mode == NUM_MODES-1) ? 0 : cur_mode + 1`.
  - On abort: `cur_mode` is unchanged.
  - Go to IDLE.

## Timing
- **Reset values**: all outputs 0 except `udp_data_length = 2`. State IDLE, `key_stable = 1`.
- **Request**: rises 1 cycle after `udp_tx_ready` is sampled high in a REQ state. It stays high until the cycle after ack.
- **Frame data**: valid rises in the cycle after ack and stays contiguous for exactly N cycles (N = 2 or `len`). `app_tx_data` is registered alongside valid.
- **`udp_data_length`**: stable for the whole request/ack/data window of each frame.
- **Start latency**: `start` accepted in IDLE puts the block in CMD_REQ at the next edge, with `busy` high at that edge.
- **Gap**: the last command valid falls, then `GAP_CYC+1` cycles elapse before DAT_REQ.
- **Reset mid-frame**: all outputs drop to reset values immediately. There is no partial resume.
- **Ack and timeout in the same cycle**: ack wins.

## Test plan
- **Start, mode 0**: `start` pulse; mode 0, `len=3`, payload AF,0F,F0; ready=1; ack 2 cycles after request.
  - Command frame 00,02 with length 2.
  - Data frame AF,0F,F0 with length 3.
  - `cur_mode` goes to 1.
- **Key bounce**: `key_n` glitch shorter than `DEBOUNCE_CYC` (bench uses 16) → no sequence. Stable low for 17 cycles → exactly one sequence.
- **Mode wrap**: `NUM_MODES=4`, four consecutive triggers; mode lengths 1,5,8,12 → command byte 1 is 02,03,04,05. Lengths sent are 1,5,8,8 (12 clamped to `MAX_LEN`). `cur_mode` wraps 3→0.
- **Ack timeout**: no `app_tx_ack` for `ACK_TIMEOUT` cycles in DAT_ACK (bench uses 100).
  - Request falls and `timeout_err` goes to 1.
  - `cur_mode` is unchanged and the block returns to IDLE.
  - The next trigger clears `timeout_err`.
- **Zero length / busy trigger**: `len=0` → command frame only, `cur_mode` advances. A `start` pulse while `busy` is ignored.
- **Reset mid-data**: `rst_n` low during DAT_DATA → request, valid and `busy` are 0 in the same cycle, and `udp_data_length` is 2.
